reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state changes SHALL occur on the rising edge of clk.
REQ-002 The block SHALL provide these ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
issueValid  in  1  decode stage holds a valid instruction
rsD  in  5  source register A of the decode instruction
rtD  in  5  source register B of the decode instruction
useRsD  in  1  instruction reads rsD
useRtD  in  1  instruction reads rtD
rdD  in  5  destination register of the decode instruction
regWriteD  in  1  instruction writes rdD
latD  in  2  cycles after issue before the result is forwardable (0=ALU, 1=load, 2-3=multicycle)
flush  in  1  squash: clear all pending entries
stall  out  1  decode must hold; no issue this cycle
issueFire  out  1  instruction issues this cycle
busyMask  out  32  bit r set when register r has a pending, not-yet-forwardable result
stallCount  out  16  saturating count of stalled cycles

Function
REQ-003 The block SHALL hold one 2-bit countdown cnt[r] for each register r in 1..31; register 0 SHALL have no entry and SHALL never be busy.
REQ-004 busyMask[r] SHALL be 1 iff cnt[r] != 0, evaluated combinationally from current state.
REQ-005 hazRs SHALL be useRsD && rsD != 0 && cnt[rsD] != 0; hazRt SHALL be the same test applied to rtD.
REQ-006 hazWaw SHALL be regWriteD && rdD != 0 && cnt[rdD] != 0.
REQ-007 stall SHALL be issueValid && !flush && (hazRs || hazRt || hazWaw), combinationally in the same cycle.
REQ-008 issueFire SHALL be issueValid && !flush && !stall.
REQ-009 Each clock, every nonzero cnt[r] SHALL decrement by 1, and every zero cnt[r] SHALL hold at 0.
REQ-010 When issueFire && regWriteD && rdD != 0, cnt[rdD] SHALL load latD on that edge, overriding the decrement.
REQ-011 With latD=0, no busy state SHALL be created; the result SHALL be covered by EX/MEM/WB forwarding.
REQ-012 A source with cnt=1 SHALL stall the current cycle and SHALL be issuable in the next cycle (cnt=0). Load-use therefore costs exactly 1 stall cycle, and latD=3 costs 3 stall cycles for a dependent instruction that immediately follows.
REQ-013 When flush=1, all cnt[r] SHALL become 0 on that edge; stall and issueFire SHALL be 0 in that cycle; no new entry SHALL load, even if issueValid=1.
REQ-014 stallCount SHALL increment by 1 on each edge where stall=1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-015 When rsD == rtD and both are pending, the block SHALL produce a single stall (not a double count); stallCount SHALL still increment only by 1 per cycle.
REQ-016 If issueValid=0, no state SHALL change except the decrements and stallCount holding.
REQ-017 An instruction whose rdD equals its own rsD SHALL be evaluated against pre-issue state only (read-before-set).

Reset
REQ-018 While rst=1 at an edge, all cnt[r] SHALL become 0 and stallCount SHALL become 0; rst SHALL have priority over flush and issue.
REQ-019 After reset, outputs SHALL be stall=0, issueFire=issueValid, busyMask=0, stallCount=0.
REQ-020 A reset asserted while entries are pending SHALL clear them in one edge; the next cycle SHALL show no stall for any source.

Verification
REQ-021 Load-use: issue lw rd=5, latD=1; next cycle add rs=5 -> stall=1 for 1 cycle, then issueFire=1; stallCount=1.
REQ-022 Multicycle: issue mul rd=8, latD=3; next cycle dependent rt=8 -> stall for 3 consecutive cycles, busyMask[8] reads 1,1,1 then 0; stallCount=3.
REQ-023 ALU back-to-back: add rd=3, latD=0, then sub rs=3 -> no stall; busyMask stays 0.
REQ-024 Register zero: load with rd=0, latD=1, then rs=0 -> no stall; busyMask[0]=0.
REQ-025 Flush/reset mid-operation: mul rd=9, latD=3, flush the next cycle -> busyMask=0 after the edge, dependent instruction issues immediately. Repeat with rst instead of flush -> stallCount also reads 0.
REQ-026 WAW plus saturation: pending rd=4 with cnt=2 and a new writer rd=4 -> stall until cnt=0. Preload stallCount to 16'hFFFE and hold stall for 3 cycles -> stallCount reads 16'hFFFF and holds.

Source files
------------

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Register-result scoreboard for an in-order decode stage. Every
// architectural register 1..31 has a 2-bit countdown giving the number of
// cycles until its pending result can be forwarded. An instruction in decode
// that reads a counting register (RAW) or writes one (WAW) is held in decode.
// Register 0 is hard-wired and never tracked.
//
// Ports
//   clk         in   1  system clock, all state changes on the rising edge
//   rst         in   1  synchronous active-high reset (priority over all)
//   issueValid  in   1  decode stage holds a valid instruction
//   rsD         in   5  source register A of the decode instruction
//   rtD         in   5  source register B of the decode instruction
//   useRsD      in   1  instruction reads rsD
//   useRtD      in   1  instruction reads rtD
//   rdD         in   5  destination register of the decode instruction
//   regWriteD   in   1  instruction writes rdD
//   latD        in   2  cycles until the result is forwardable (0 = ALU)
//   flush       in   1  squash: clear every pending entry
//   stall       out  1  decode must hold this cycle
//   issueFire   out  1  instruction issues this cycle
//   busyMask    out 32  bit r set while register r is still counting down
//   stallCount  out 16  saturating count of stalled cycles
// ---------------------------------------------------------------------------
module reg_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        issueValid,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        useRsD,
    input  logic        useRtD,
    input  logic [4:0]  rdD,
    input  logic        regWriteD,
    input  logic [1:0]  latD,
    input  logic        flush,
    output logic        stall,
    output logic        issueFire,
    output logic [31:0] busyMask,
    output logic [15:0] stallCount
);

    // Countdown per register; entry 0 intentionally does not exist.
    logic [1:0]  cntReg  [31:1];
    logic [1:0]  cntNext [31:1];
    logic [15:0] stallCountNext;

    logic        hazRs;
    logic        hazRt;
    logic        hazWaw;
    logic        loadEn;

    // Busy view of the countdown state; bit 0 is constant zero.
    always_comb begin
        busyMask = 32'h0000_0000;
        for (int r = 1; r < 32; r++) begin
            busyMask[r] = (cntReg[r] != 2'd0);
        end
    end

    // Hazard detection and issue decision. busyMask[0] is always 0, so the
    // explicit register-zero checks are redundant but keep the intent clear.
    // rsD == rtD naturally yields a single stall: the terms are OR-ed.
    always_comb begin
        hazRs     = useRsD    && (rsD != 5'd0) && busyMask[rsD];
        hazRt     = useRtD    && (rtD != 5'd0) && busyMask[rtD];
        hazWaw    = regWriteD && (rdD != 5'd0) && busyMask[rdD];
        stall     = issueValid && !flush && (hazRs || hazRt || hazWaw);
        issueFire = issueValid && !flush && !stall;
        loadEn    = issueFire && regWriteD && (rdD != 5'd0);
    end

    // Next countdown values: flush clears, a fired writer loads its latency
    // (evaluated against pre-issue state), otherwise count down toward zero.
    always_comb begin
        for (int r = 1; r < 32; r++) begin
            cntNext[r] = cntReg[r];
            if (flush) begin
                cntNext[r] = 2'd0;
            end else if (loadEn && (rdD == 5'(r))) begin
                cntNext[r] = latD;
            end else if (cntReg[r] != 2'd0) begin
                cntNext[r] = cntReg[r] - 2'd1;
            end else begin
                cntNext[r] = 2'd0;
            end
        end
    end

    // Saturating stall counter next value.
    always_comb begin
        stallCountNext = stallCount;
        if (stall && (stallCount != 16'hFFFF)) begin
            stallCountNext = stallCount + 16'd1;
        end else begin
            stallCountNext = stallCount;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < 32; r++) begin
                cntReg[r] <= 2'd0;
            end
            stallCount <= 16'h0000;
        end else begin
            for (int r = 1; r < 32; r++) begin
                cntReg[r] <= cntNext[r];
            end
            stallCount <= stallCountNext;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_scoreboard
//
// Directed, table-driven bench for reg_scoreboard. Each table row is one
// clock cycle: inputs are applied just after a rising edge, and the outputs
// (combinational stall/issueFire/busyMask plus the current stallCount) are
// compared at the following falling edge. A hand-written sequence afterwards
// drives stallCount up to saturation.
// ---------------------------------------------------------------------------
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issueValid;
    logic [4:0]  rsD;
    logic [4:0]  rtD;
    logic        useRsD;
    logic        useRtD;
    logic [4:0]  rdD;
    logic        regWriteD;
    logic [1:0]  latD;
    logic        flush;
    logic        stall;
    logic        issueFire;
    logic [31:0] busyMask;
    logic [15:0] stallCount;

    int nTests = 0;
    int nFail  = 0;

    reg_scoreboard dut (
        .clk        (clk),
        .rst        (rst),
        .issueValid (issueValid),
        .rsD        (rsD),
        .rtD        (rtD),
        .useRsD     (useRsD),
        .useRtD     (useRtD),
        .rdD        (rdD),
        .regWriteD  (regWriteD),
        .latD       (latD),
        .flush      (flush),
        .stall      (stall),
        .issueFire  (issueFire),
        .busyMask   (busyMask),
        .stallCount (stallCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  rs;
        logic        urs;
        logic [4:0]  rt;
        logic        urt;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  lat;
        logic        fl;
        logic        eStall;
        logic        eFire;
        logic [31:0] eBusy;
        logic [15:0] eCnt;
    } vec_t;

    localparam int NVEC = 32;
    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic rst_, input logic iv, input logic [4:0] rs, input logic urs,
        input logic [4:0] rt, input logic urt, input logic [4:0] rd, input logic rw,
        input logic [1:0] lat, input logic fl, input logic eStall, input logic eFire,
        input logic [31:0] eBusy, input logic [15:0] eCnt);
        vec_t v;
        v.rst = rst_;  v.iv = iv;   v.rs = rs;  v.urs = urs;
        v.rt = rt;     v.urt = urt; v.rd = rd;  v.rw = rw;
        v.lat = lat;   v.fl = fl;
        v.eStall = eStall; v.eFire = eFire; v.eBusy = eBusy; v.eCnt = eCnt;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rd, input logic rw, input logic [1:0] lat);
        issueValid = iv;   rsD = rs;  useRsD = urs;
        rtD = 5'd0;        useRtD = 1'b0;
        rdD = rd;          regWriteD = rw; latD = lat;
        flush = 1'b0;      rst = 1'b0;
    endtask

    localparam logic [31:0] B4  = 32'h0000_0010;
    localparam logic [31:0] B5  = 32'h0000_0020;
    localparam logic [31:0] B8  = 32'h0000_0100;
    localparam logic [31:0] B9  = 32'h0000_0200;
    localparam logic [31:0] B10 = 32'h0000_0400;
    localparam logic [31:0] B12 = 32'h0000_1000;

    initial begin
        int model;
        int k;

        //           rst iv  rs  urs rt  urt rd  rw lat fl  stall fire busy  cnt
        // idle after reset: nothing busy, issueFire follows issueValid
        vecs[0]  = mk(0, 1, 0,  0, 0,  0, 0,  0, 0, 0,  0, 1, 32'h0, 16'd0);
        // load-use: lw rd=5 lat1, then add rs=5 stalls exactly one cycle
        vecs[1]  = mk(0, 1, 0,  0, 0,  0, 5,  1, 1, 0,  0, 1, 32'h0, 16'd0);
        vecs[2]  = mk(0, 1, 5,  1, 0,  0, 6,  1, 0, 0,  1, 0, B5,    16'd0);
        vecs[3]  = mk(0, 1, 5,  1, 0,  0, 6,  1, 0, 0,  0, 1, 32'h0, 16'd1);
        // multicycle: mul rd=8 lat3, dependent rt=8 stalls three cycles
        vecs[4]  = mk(0, 1, 0,  0, 0,  0, 8,  1, 3, 0,  0, 1, 32'h0, 16'd1);
        vecs[5]  = mk(0, 1, 0,  0, 8,  1, 0,  0, 0, 0,  1, 0, B8,    16'd1);
        vecs[6]  = mk(0, 1, 0,  0, 8,  1, 0,  0, 0, 0,  1, 0, B8,    16'd2);
        vecs[7]  = mk(0, 1, 0,  0, 8,  1, 0,  0, 0, 0,  1, 0, B8,    16'd3);
        vecs[8]  = mk(0, 1, 0,  0, 8,  1, 0,  0, 0, 0,  0, 1, 32'h0, 16'd4);
        // ALU back-to-back: latD=0 creates no busy state
        vecs[9]  = mk(0, 1, 0,  0, 0,  0, 3,  1, 0, 0,  0, 1, 32'h0, 16'd4);
        vecs[10] = mk(0, 1, 3,  1, 0,  0, 0,  0, 0, 0,  0, 1, 32'h0, 16'd4);
        // register zero: never tracked
        vecs[11] = mk(0, 1, 0,  0, 0,  0, 0,  1, 1, 0,  0, 1, 32'h0, 16'd4);
        vecs[12] = mk(0, 1, 0,  1, 0,  1, 0,  0, 0, 0,  0, 1, 32'h0, 16'd4);
        // rd == rs: judged on pre-issue state, then counts down with issueValid=0
        vecs[13] = mk(0, 1, 10, 1, 0,  0, 10, 1, 2, 0,  0, 1, 32'h0, 16'd4);
        vecs[14] = mk(0, 0, 10, 1, 0,  0, 10, 1, 2, 0,  0, 0, B10,   16'd4);
        vecs[15] = mk(0, 0, 10, 1, 0,  0, 10, 1, 2, 0,  0, 0, B10,   16'd4);
        vecs[16] = mk(0, 0, 10, 1, 0,  0, 10, 1, 2, 0,  0, 0, 32'h0, 16'd4);
        // rs == rt both pending: one stall per cycle
        vecs[17] = mk(0, 1, 0,  0, 0,  0, 12, 1, 2, 0,  0, 1, 32'h0, 16'd4);
        vecs[18] = mk(0, 1, 12, 1, 12, 1, 0,  0, 0, 0,  1, 0, B12,   16'd4);
        vecs[19] = mk(0, 1, 12, 1, 12, 1, 0,  0, 0, 0,  1, 0, B12,   16'd5);
        vecs[20] = mk(0, 1, 12, 1, 12, 1, 0,  0, 0, 0,  0, 1, 32'h0, 16'd6);
        // flush mid-operation: no stall/fire, no new entry for rd=11
        vecs[21] = mk(0, 1, 0,  0, 0,  0, 9,  1, 3, 0,  0, 1, 32'h0, 16'd6);
        vecs[22] = mk(0, 1, 9,  1, 0,  0, 11, 1, 3, 1,  0, 0, B9,    16'd6);
        vecs[23] = mk(0, 1, 9,  1, 11, 1, 0,  0, 0, 0,  0, 1, 32'h0, 16'd6);
        // WAW: pending rd=4 cnt=2, new writer rd=4 waits until cnt=0
        vecs[24] = mk(0, 1, 0,  0, 0,  0, 4,  1, 2, 0,  0, 1, 32'h0, 16'd6);
        vecs[25] = mk(0, 1, 0,  0, 0,  0, 4,  1, 1, 0,  1, 0, B4,    16'd6);
        vecs[26] = mk(0, 1, 0,  0, 0,  0, 4,  1, 1, 0,  1, 0, B4,    16'd7);
        vecs[27] = mk(0, 1, 0,  0, 0,  0, 4,  1, 1, 0,  0, 1, 32'h0, 16'd8);
        vecs[28] = mk(0, 0, 0,  0, 0,  0, 0,  0, 0, 0,  0, 0, B4,    16'd8);
        // reset mid-operation: clears entries and stallCount in one edge
        vecs[29] = mk(0, 1, 0,  0, 0,  0, 9,  1, 3, 0,  0, 1, 32'h0, 16'd8);
        vecs[30] = mk(1, 0, 9,  1, 0,  0, 0,  0, 0, 0,  0, 0, B9,    16'd8);
        vecs[31] = mk(0, 1, 9,  1, 0,  0, 0,  0, 0, 0,  0, 1, 32'h0, 16'd0);

        // Initial reset
        rst = 1'b1; issueValid = 1'b0; rsD = 5'd0; rtD = 5'd0;
        useRsD = 1'b0; useRtD = 1'b0; rdD = 5'd0; regWriteD = 1'b0;
        latD = 2'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            rst = vecs[i].rst;   issueValid = vecs[i].iv;
            rsD = vecs[i].rs;    useRsD = vecs[i].urs;
            rtD = vecs[i].rt;    useRtD = vecs[i].urt;
            rdD = vecs[i].rd;    regWriteD = vecs[i].rw;
            latD = vecs[i].lat;  flush = vecs[i].fl;
            @(negedge clk);
            check($sformatf("row%0d stall", i),      32'(stall),      32'(vecs[i].eStall));
            check($sformatf("row%0d issueFire", i),  32'(issueFire),  32'(vecs[i].eFire));
            check($sformatf("row%0d busyMask", i),   busyMask,        vecs[i].eBusy);
            check($sformatf("row%0d stallCount", i), 32'(stallCount), 32'(vecs[i].eCnt));
            @(posedge clk);
            #1;
        end

        // Saturation: accumulate 16'hFFFE stalls (writer to r1, then a
        // dependent reader stalls for exactly latD cycles), then hold stall.
        model = 0;
        while (model < 65534) begin
            k = (65534 - model < 3) ? (65534 - model) : 3;
            drive(1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 2'(k));
            @(posedge clk); #1;
            drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 2'd0);
            repeat (k) @(posedge clk);
            #1;
            model += k;
        end
        check("preload stallCount", 32'(stallCount), 32'h0000_FFFE);

        drive(1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 2'd3);
        @(posedge clk); #1;
        drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 2'd0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("sat%0d stall", j), 32'(stall), 32'h1);
            @(posedge clk); #1;
            check($sformatf("sat%0d stallCount", j), 32'(stallCount), 32'h0000_FFFF);
        end
        @(negedge clk);
        check("sat release issueFire", 32'(issueFire), 32'h1);
        @(posedge clk); #1;
        check("sat hold stallCount", 32'(stallCount), 32'h0000_FFFF);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
